// File: rtl/age_select.sv
// Oldest-first RS select over an age matrix; grant is combinational (0-cycle) from reqs.
// Backpressure: rr_stall/flush suppress the grant; a multi-cycle FU blocks grants while busy.
module age_select #(
  parameter int RS_ENTRIES  = 8,
  parameter int BUSY_CYCLES = 1,
  localparam int IW = $clog2(RS_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [IW-1:0]         alloc_idx,
  input  logic [RS_ENTRIES-1:0] reqs,
  input  logic                  rr_stall,
  input  logic                  flush,
  output logic [IW-1:0]         grant,
  output logic [RS_ENTRIES-1:0] grant_onehot,
  output logic                  grant_valid,
  output logic                  fu_busy
);

  typedef enum logic {READY, BUSY} state_t;

  state_t                                 state_q, state_d;
  logic [3:0]                             busy_cnt_q, busy_cnt_d;
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0]  older_q, older_d;
  logic [RS_ENTRIES-1:0]                  blocked;
  logic [RS_ENTRIES-1:0]                  eligible;
  logic [IW-1:0]                          sel_idx;

  // A new entry is younger than every other entry: clear its row, set its column.
  always_comb begin
    older_d = older_q;
    if (alloc_valid) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        older_d[alloc_idx][i] = 1'b0;
        older_d[i][alloc_idx] = (i != int'(alloc_idx));
      end
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      for (int j = 0; j < RS_ENTRIES; j++) begin
        if (j != i && reqs[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
    eligible = reqs & ~blocked;
  end

  // Lowest index wins among eligible entries; only matters before the matrix is populated.
  always_comb begin
    sel_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = IW'(i);
    end
  end

  assign grant_valid  = rst && (|reqs) && !rr_stall && !flush && (state_q == READY);
  assign grant        = grant_valid ? sel_idx : '0;
  assign grant_onehot = grant_valid ? ({{(RS_ENTRIES-1){1'b0}}, 1'b1} << sel_idx) : '0;
  assign fu_busy      = (state_q == BUSY);

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    if (flush) begin
      state_d    = READY;
      busy_cnt_d = 4'd0;
    end else begin
      case (state_q)
        READY: begin
          if (grant_valid && BUSY_CYCLES > 1) begin
            state_d    = BUSY;
            busy_cnt_d = 4'(BUSY_CYCLES - 1);
          end
        end
        BUSY: begin
          busy_cnt_d = busy_cnt_q - 4'd1;
          if (busy_cnt_q == 4'd1) state_d = READY;
        end
        default: state_d = READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= READY;
      busy_cnt_q <= 4'd0;
      older_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      older_q    <= older_d;
    end
  end

endmodule

// File: doc/age_select.md
Name: age_select

Overview:
- Oldest-first select arbiter for one reservation-station pipe. It replaces the round-robin select feeding wakeup and the payload RAM.
- Tracks the relative age of RS entries in an age matrix that is updated on every dispatch allocation.
- Grants the oldest requesting entry each cycle and sequences issue around a non-pipelined functional unit (occupancy counter) and register-read backpressure.
- Output grant/grant_valid drive wakeup retirement and the payload RAM read index.

Parameters:
- RS_ENTRIES, 8, number of reservation-station entries. Must be a power of 2 and at least 2.
- BUSY_CYCLES, 1, number of cycles the FU is occupied per issued op. 1 means fully pipelined. Legal range is 1..15.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- alloc_valid  input  1  dispatch writes an entry this cycle.
- alloc_idx  input  $clog2(RS_ENTRIES)  entry being allocated (wakeup free_entry_out).
- reqs  input  RS_ENTRIES  per-entry ready-to-issue requests from wakeup.
- rr_stall  input  1  register read cannot accept a packet this cycle.
- flush  input  1  pipeline flush; clears sequencing state.
- grant  output  $clog2(RS_ENTRIES)  index of the selected entry.
- grant_onehot  output  RS_ENTRIES  one-hot form of grant; all zeros when grant_valid=0.
- grant_valid  output  1  an issue fires this cycle.
- fu_busy  output  1  FU occupancy counter is nonzero.

Behaviour:
- Age matrix `older[i][j]`: 1 means entry i is older than entry j. Diagonal bits are don't-care and are never used.
- Allocation of entry k, registered at the edge where alloc_valid=1:
  - `older[k][*] <= 0`
  - `older[*][k] <= 1` for all i != k
  - The new entry becomes the youngest.
- Select is combinational from `reqs` and the current matrix.
  - Entry i is eligible if `reqs[i]` is set and no j exists with `reqs[j] & older[j][i]`.
  - Exactly one entry is eligible whenever `reqs != 0`, given a consistent matrix.
  - Tie fallback for a never-allocated or reset matrix: lowest index wins.
- `grant_valid = (reqs != 0) & ~rr_stall & ~flush & (state == READY)`.
  - `grant` and `grant_onehot` reflect the selected entry whenever grant_valid=1.
  - When grant_valid=0, `grant` is 0.
  - Latency: zero cycles from reqs to grant. Wakeup must drop `reqs[grant]` in the next cycle.
- FSM states:
  - READY:
    - On grant_valid with BUSY_CYCLES>1, load `busy_cnt <= BUSY_CYCLES-1` and go to BUSY.
    - On grant_valid with BUSY_CYCLES==1, stay in READY.
  - BUSY:
    - Each cycle, `busy_cnt <= busy_cnt-1`.
    - When busy_cnt reaches 1 this cycle (it becomes 0), go to READY.
    - No grants are issued in BUSY. rr_stall does not pause the count.
- `fu_busy = (state == BUSY)`.
- flush:
  - Forces grant_valid=0 in the same cycle.
  - Next state is READY and busy_cnt is 0.
  - The age matrix is not cleared; entries are reallocated on redispatch.
- Reset (rst=0, asynchronous):
  - state=READY, busy_cnt=0, age matrix all zeros.
  - All outputs are 0 during and immediately after reset.
  - Reset asserted mid-BUSY aborts the count immediately.
- Simultaneous alloc and grant in the same cycle:
  - Select uses the pre-update matrix.
  - The alloc update still lands at the edge.
  - Allocating an entry whose `reqs` bit is set is illegal and must be caught by an assertion in the bench.
- Reallocation of a freed index overwrites its row and column, so no explicit dealloc is needed.
- rr_stall held for N cycles: grant_valid stays 0, no state change, and the same oldest entry wins once the stall drops (requests are stable).

Test Plan:
- Reset then allocate entries 3, 1, 6 in consecutive cycles, then `reqs = 8'b0100_1010` → grant=3, grant_onehot=8'h08, grant_valid=1. Drop bit 3 → grant=1. Drop bit 1 → grant=6.
- Age wrap: allocate 5 then 2, grant 5, reallocate 5, then `reqs = {2,5}` → grant=2 (5 is now youngest).
- BUSY_CYCLES=4, `reqs = 8'h03` held → grant_valid pulses once, then fu_busy=1 for 3 cycles, then the next grant is on cycle 4. Total grants = 2 within 5 cycles.
- rr_stall high for 3 cycles with `reqs = 8'h10` → grant_valid=0 for those 3 cycles. Stall drops → grant=4, grant_valid=1 on the same cycle.
- BUSY_CYCLES=8, grant, then flush asserted 2 cycles later → fu_busy=0 the next cycle and a new request is granted immediately after flush deasserts.
- Assert rst low asynchronously mid-BUSY, between clock edges → fu_busy and grant_valid go to 0 without waiting for clk. After release, an empty matrix with `reqs = 8'h44` → grant=2 (lowest-index fallback).
